// File: rtl/i2c_sram_pkg.sv
// i2c_sram_pkg: state codes and width defaults shared by the I2C-attached SRAM.
package i2c_sram_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int STATE_W    = 33;
   localparam int DEV_ADDR_W = 7;
   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      DEV_ADDR = 4'd1,
      DEV_ACK  = 4'd2,
      MEM_ADDR = 4'd3,
      MEM_ACK  = 4'd4,
      WR_DATA  = 4'd5,
      WR_ACK   = 4'd6,
      RD_DATA  = 4'd7,
      RD_ACK   = 4'd8,
      WAIT_STOP = 4'd9
   } state_t;
endpackage

// File: rtl/i2c_sram_mem.sv
// i2c_sram_mem: single-port SRAM, synchronous write, combinational read.
// With MEM_INIT_EN defined, reset loads mem[i] = i (register array); otherwise contents start undefined.
module i2c_sram_mem
   import i2c_sram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [2**ADDR_W];
`ifdef MEM_INIT_EN
   always_ff @(posedge clk) begin
      if (reset)
         for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= DATA_W'(i);
      else if (i_we)
         r_mem[i_addr] <= i_wdata;
   end
`else
   always_ff @(posedge clk) begin
      if (i_we && !reset) r_mem[i_addr] <= i_wdata;
   end
`endif
   assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/i2c_sram_embedded.sv
// i2c_sram_embedded: I2C slave fronting a 2**ADDR_W x 8 SRAM; SCL/SDA oversampled, SDA open-drain.
// Define MEM_INIT_EN to make reset preload mem[i] = i.
module i2c_sram_embedded
   import i2c_sram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  scl,
   inout  wire                   sda,
   input  logic [DEV_ADDR_W-1:0] my_addr,
   output logic [DATA_W-1:0]     curr_data,
   output logic [DEV_ADDR_W-1:0] rcvd_device_address,
   output logic [STATE_W-1:0]    state,
   output logic                  rcvd_mode
);
   state_t                r_state, w_state;
   logic [1:0]            r_scl_s, r_sda_s;
   logic                  r_scl_d, r_sda_d;
   logic [3:0]            r_cnt, w_cnt;
   logic [DATA_W-1:0]     r_sh, w_sh, r_curr, w_curr, w_rdata, w_byte;
   logic [ADDR_W-1:0]     r_ptr, w_ptr;
   logic [DEV_ADDR_W-1:0] r_dev, w_dev;
   logic                  r_mode, w_mode, r_oe, w_oe, w_we, w_ld;
   logic                  w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
   assign w_scl   = r_scl_s[1];
   assign w_sda   = r_sda_s[1];
   assign w_rise  = w_scl & ~r_scl_d;
   assign w_fall  = ~w_scl & r_scl_d;
   assign w_start = w_scl & r_sda_d & ~w_sda;
   assign w_stop  = w_scl & ~r_sda_d & w_sda;
   assign w_byte  = {r_sh[DATA_W-2:0], w_sda};
   assign sda     = r_oe ? 1'b0 : 1'bz;
   assign curr_data           = r_curr;
   assign rcvd_device_address = r_dev;
   assign rcvd_mode           = r_mode;
   assign state               = STATE_W'(r_state);
   i2c_sram_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
      .clk(clk), .reset(reset), .i_we(w_we), .i_addr(r_ptr), .i_wdata(w_byte), .o_rdata(w_rdata)
   );
   // Synchronizers reset to the idle-bus level so reset release cannot fake a START/STOP.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_s <= '1; r_sda_s <= '1; r_scl_d <= 1'b1; r_sda_d <= 1'b1;
         r_state <= IDLE; r_cnt <= '0; r_sh <= '0; r_ptr <= '0;
         r_curr <= '0; r_dev <= '0; r_mode <= 1'b0; r_oe <= 1'b0;
      end else begin
         r_scl_s <= {r_scl_s[0], scl}; r_sda_s <= {r_sda_s[0], sda};
         r_scl_d <= w_scl; r_sda_d <= w_sda;
         r_state <= w_state; r_cnt <= w_cnt; r_sh <= w_sh; r_ptr <= w_ptr;
         r_curr <= w_curr; r_dev <= w_dev; r_mode <= w_mode; r_oe <= w_oe;
      end
   end
   always_comb begin
      w_state = r_state; w_cnt = r_cnt; w_sh = r_sh; w_ptr = r_ptr;
      w_curr = r_curr; w_dev = r_dev; w_mode = r_mode; w_oe = r_oe;
      w_we = 1'b0; w_ld = 1'b0;
      if (w_start) begin
         w_state = DEV_ADDR; w_cnt = '0; w_oe = 1'b0;
      end else if (w_stop) begin
         w_state = IDLE; w_oe = 1'b0;
      end else
         case (r_state)
            DEV_ADDR, MEM_ADDR, WR_DATA:
               if (w_rise) begin
                  w_sh = w_byte; w_cnt = r_cnt + 4'd1;
                  if (r_state == DEV_ADDR && r_cnt == 4'd6) w_dev = w_byte[DEV_ADDR_W-1:0];
                  if (r_cnt == 4'd7) begin
                     w_cnt = '0;
                     case (r_state)
                        DEV_ADDR: begin w_mode = w_sda; w_state = (r_dev == my_addr) ? DEV_ACK : WAIT_STOP; end
                        MEM_ADDR: begin w_ptr = ADDR_W'(w_byte); w_state = MEM_ACK; end
                        default:  begin w_we = 1'b1; w_curr = w_byte; w_state = WR_ACK; end
                     endcase
                  end
               end
            // First SCL fall pulls SDA for the ACK clock, second fall releases and moves on.
            DEV_ACK, MEM_ACK, WR_ACK:
               if (w_fall) begin
                  w_oe = ~r_oe;
                  if (r_oe) begin
                     w_state = (r_state == DEV_ACK) ? MEM_ADDR : WR_DATA;
                     if (r_state == WR_ACK) w_ptr = r_ptr + ADDR_W'(1);
                     w_ld = (r_state == MEM_ACK) && r_mode;
                  end
               end
            RD_DATA:
               if (w_rise) w_cnt = r_cnt + 4'd1;
               else if (w_fall) begin
                  if (r_cnt == 4'd8) begin
                     w_oe = 1'b0; w_cnt = '0; w_state = RD_ACK;
                  end else begin
                     w_oe = ~r_sh[DATA_W-2]; w_sh = r_sh << 1;
                  end
               end
            RD_ACK:
               if (w_rise) begin
                  if (w_sda) w_state = WAIT_STOP;
                  else begin w_ptr = r_ptr + ADDR_W'(1); w_cnt = 4'd1; end
               end else if (w_fall && r_cnt == 4'd1) w_ld = 1'b1;
            default: ;
         endcase
      if (w_ld) begin
         w_sh = w_rdata; w_curr = w_rdata; w_oe = ~w_rdata[DATA_W-1]; w_cnt = '0; w_state = RD_DATA;
      end
   end
endmodule

// File: tb/tb_i2c_sram_embedded.sv
// tb_i2c_sram_embedded: directed I2C master transactions against the SRAM slave.
module tb_i2c_sram_embedded;
   localparam int Q = 40;
   logic        clk = 1'b0, reset = 1'b1, scl = 1'b1, m_low = 1'b0;
   logic [6:0]  my_addr = 7'h3C;
   logic [7:0]  curr_data;
   logic [6:0]  rcvd_device_address;
   logic [32:0] state;
   logic        rcvd_mode;
   wire         sda;
   int          checks = 0, failures = 0;
   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);
   always #5 clk = ~clk;
   i2c_sram_embedded dut (
      .clk(clk), .reset(reset), .scl(scl), .sda(sda), .my_addr(my_addr),
      .curr_data(curr_data), .rcvd_device_address(rcvd_device_address),
      .state(state), .rcvd_mode(rcvd_mode)
   );
   task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic put_bit(input logic b);
      #Q m_low = ~b; #Q scl = 1'b1; #(2*Q) scl = 1'b0;
   endtask
   task automatic get_bit(output logic b);
      #Q m_low = 1'b0; #Q scl = 1'b1; #Q b = sda; #Q scl = 1'b0;
   endtask
   task automatic start_c;
      #Q m_low = 1'b0; #Q scl = 1'b1; #(2*Q) m_low = 1'b1; #(2*Q) scl = 1'b0;
   endtask
   task automatic stop_c;
      #Q m_low = 1'b1; #Q scl = 1'b1; #(2*Q) m_low = 1'b0; #(2*Q);
   endtask
   task automatic send_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
      get_bit(ack);
   endtask
   task automatic recv_byte(input logic nack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin get_bit(b); d[i] = b; end
      put_bit(nack);
   endtask
   task automatic hdr(input logic [6:0] dev, input logic rw, input logic [7:0] a, output logic [1:0] acks);
      logic x, y;
      start_c; send_byte({dev, rw}, x); send_byte(a, y);
      acks = {x, y};
   endtask
   initial begin
      logic [1:0] h;
      logic       a0, a1, b;
      logic [7:0] d0, d1;
      repeat (2) @(posedge clk);
      #5 reset = 1'b0;
      chk("rst_curr", curr_data, 0);
      chk("rst_dev", rcvd_device_address, 0);
      chk("rst_mode", rcvd_mode, 0);
      chk("rst_state", state, 0);
      chk("rst_sda", sda, 1);
      hdr(7'h3C, 1'b0, 8'h10, h); send_byte(8'hA5, a0); send_byte(8'h5A, a1); stop_c;
      chk("wr_acks", {h, a0, a1}, 0);
      chk("wr_curr", curr_data, 'h5A);
      chk("wr_mode", rcvd_mode, 0);
      chk("wr_state", state, 0);
      hdr(7'h3C, 1'b1, 8'h10, h);
      chk("rd_acks", h, 0);
      recv_byte(1'b0, d0); recv_byte(1'b1, d1);
      chk("rd_b0", d0, 'hA5);
      chk("rd_b1", d1, 'h5A);
      chk("rd_nack_state", state, 9);
      chk("rd_mode", rcvd_mode, 1);
      stop_c;
      chk("rd_state", state, 0);
      chk("rd_dev", rcvd_device_address, 'h3C);
      chk("rd_curr", curr_data, 'h5A);
      start_c; send_byte({7'h3D, 1'b0}, a0);
      chk("mm_nack", a0, 1);
      chk("mm_state", state, 9);
      chk("mm_dev", rcvd_device_address, 'h3D);
      send_byte(8'h10, a0); send_byte(8'h00, a1);
      chk("mm_data_nacks", {a0, a1}, 'b11);
      chk("mm_state_hold", state, 9);
      stop_c;
      chk("mm_state_stop", state, 0);
      hdr(7'h3C, 1'b1, 8'h10, h); recv_byte(1'b1, d0); stop_c;
      chk("mm_mem", d0, 'hA5);
      hdr(7'h3C, 1'b0, 8'hFF, h); send_byte(8'h11, a0); send_byte(8'h22, a1); stop_c;
      chk("wrap_acks", {h, a0, a1}, 0);
      hdr(7'h3C, 1'b1, 8'hFF, h); recv_byte(1'b0, d0); recv_byte(1'b1, d1); stop_c;
      chk("wrap_ff", d0, 'h11);
      chk("wrap_rd00", d1, 'h22);
      hdr(7'h3C, 1'b1, 8'h00, h); recv_byte(1'b1, d0); stop_c;
      chk("wrap_00", d0, 'h22);
      hdr(7'h3C, 1'b0, 8'h10, h);
      repeat (4) put_bit(1'b0);
      start_c;
      chk("ab_state", state, 1);
      stop_c;
      hdr(7'h3C, 1'b1, 8'h10, h); recv_byte(1'b1, d0); stop_c;
      chk("ab_mem", d0, 'hA5);
      hdr(7'h3C, 1'b1, 8'h10, h);
      get_bit(b);
      chk("rr_b7", b, 1);
      #Q chk("rr_drive", sda, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rr_state", state, 0);
      chk("rr_sda", sda, 1);
      chk("rr_curr", curr_data, 0);
      reset = 1'b0; scl = 1'b1;
      #(4*Q);
      chk("rr_idle", state, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/i2c_sram_embedded.md
Name: i2c_sram_embedded

Overview:
- I2C slave wrapping a 256 x 8 on-chip SRAM.
- SCL and SDA are oversampled on a system clock; SDA is open-drain, with the slave only ever pulling it low.
- Transaction framing for both directions: START, 7-bit device address + R/W bit, ACK, 8-bit memory address, ACK, then data bytes.
  - Write (W): the master sends data.
  - Read (R): the slave returns data.
- Debug outputs expose the captured address and mode, the current byte and the FSM state.

Parameters:
- ADDR_W, 8: memory address width; depth = 2**ADDR_W.
- DATA_W, 8: memory word width; must be 8 for the I2C byte framing.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- scl  input  1  I2C clock from the master.
- sda  inout  1  I2C data line.
  - Driven 0 or Z only; never driven 1.
  - The external pull-up supplies the 1 level.
- my_addr  input  7  this device's I2C address.
- curr_data  output  8  last byte completed (received or loaded for transmit).
- rcvd_device_address  output  7  device address captured in the current or last transaction.
- state  output  33  FSM state code, zero-extended.
- rcvd_mode  output  1  captured R/W bit (1 = read).

Behaviour:
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer, then a 1-cycle edge detect.
  - clk frequency ≥ 8x SCL frequency; each SCL level is held ≥ 3 clk.
- Bus events:
  - START = synced sda falls while synced scl is high.
  - STOP = synced sda rises while synced scl is high.
  - Data bits are sampled on the SCL rising edge.
  - The slave updates its SDA drive on the SCL falling edge.
  - Bytes are MSB first.
- State codes: IDLE=0, DEV_ADDR=1, DEV_ACK=2, MEM_ADDR=3, MEM_ACK=4, WR_DATA=5, WR_ACK=6, RD_DATA=7, RD_ACK=8, WAIT_STOP=9.
- START from any state, including a repeated START:
  - Go to DEV_ADDR; clear the bit counter; release sda.
- STOP from any state: go to IDLE; release sda.
- DEV_ADDR:
  - Shift in 8 bits.
  - After bit 7, rcvd_device_address <= the 7 bits received.
  - After bit 8, rcvd_mode <= the 8th bit.
  - Address match (== my_addr): go to DEV_ACK.
  - Mismatch: go to WAIT_STOP with sda released (NACK).
- DEV_ACK: pull sda low for the 9th clock, then go to MEM_ADDR. This applies for both R and W.
- MEM_ADDR:
  - Shift in 8 bits to the address pointer.
  - Then go to MEM_ACK and pull sda low for the 9th clock.
  - Next state: RD_DATA if rcvd_mode=1, else WR_DATA.
- RD_DATA entry:
  - curr_data <= mem[ptr].
  - Drive bit 7 on the first SCL low phase; drive 0 bits low, release for 1 bits.
  - After 8 bits, release sda and go to RD_ACK.
- RD_ACK (sample master bit at the 9th SCL rise):
  - 0 = ACK: ptr++, load the next byte, go to RD_DATA.
  - 1 = NACK: go to WAIT_STOP.
- WR_DATA:
  - Shift in 8 bits, then mem[ptr] <= byte and curr_data <= byte.
  - Go to WR_ACK: pull sda low for the 9th clock, ptr++, return to WR_DATA.
- Pointer: wraps 0xFF -> 0x00.
- Reset:
  - state=IDLE; sda released.
  - curr_data=0, rcvd_device_address=0, rcvd_mode=0; ptr=0; counters=0.
  - Reset mid-transfer aborts immediately.
- A START or STOP arriving mid-byte discards the partial byte; no memory write occurs.

Optional Feature:
- Macro: MEM_INIT_EN.
- Defined: reset also loads mem[i] = i for all i (register-based array).
- Undefined: the memory is an inferred RAM with no reset; contents are undefined until written.

Decomposition:
- Package i2c_sram_pkg holds:
  - state code constants (IDLE..WAIT_STOP);
  - STATE_W=33;
  - DEV_ADDR_W=7;
  - the ADDR_W and DATA_W defaults.
- Sub-module i2c_sram_mem: single-port 256x8 array with synchronous write, combinational read, and the optional init.
- Top level: synchronizers, edge detect, FSM, shift registers.

Test Plan:
- Reset asserted for 2 clk:
  - all outputs 0, state=0;
  - sda reads 1 (released).
- Read with MEM_INIT_EN, my_addr=0x3C:
  - Stimulus: START, 0x3C+R, mem addr 0x7C, read 2 bytes with master ACK then NACK, then STOP.
  - Response: slave ACKs 9th clocks; bytes 0x7C then 0x7D; rcvd_mode=1; rcvd_device_address=0x3C; state returns to 0.
- Write then read:
  - Write: START, 0x3C+W, mem addr 0x10, data 0xA5, 0x5A, STOP.
  - Read back from 0x10 returns 0xA5, 0x5A; curr_data=0x5A after the write.
- Address mismatch, my_addr=0x3C:
  - Stimulus: 0x3D+W is sent, followed by 2 bytes.
  - Response: sda high on the 9th clock; state=9 until STOP; memory unchanged; rcvd_device_address=0x3D.
- Wrap:
  - Stimulus: write 0x11, 0x22 at 0xFF.
  - Response: mem[0xFF]=0x11, mem[0x00]=0x22.
- Aborts:
  - Repeated START after 4 data bits: state=1, no memory write.
  - reset mid-RD_DATA: state=0, sda released next clk.
